// File: rtl/alu_add_arbiter.sv
// alu_add_arbiter: two-requester arbiter in front of a registered adder.
// Each grant captures the winner's operands. One cycle later the zero-extended
// sum is registered, and the result is then held with res_valid_o until the
// consumer accepts it.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// When it is undefined, requester 0 has fixed priority.
module alu_add_arbiter #(
    parameter int DATA_W = 4,
    parameter int SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [DATA_W-1:0] a0_i,
    input  logic [DATA_W-1:0] b0_i,
    input  logic [DATA_W-1:0] a1_i,
    input  logic [DATA_W-1:0] b1_i,
    output logic [1:0]        gnt_o,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [SUM_W-1:0]  res_o,
    output logic              res_id_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              id_q;
    logic              last_q;
    logic [SUM_W-1:0]  res_q;
    logic              win;
    logic [1:0]        gnt;

    // Winner selection among the live request bits.
    always_comb begin
        win = 1'b0;
        case (req_i)
            2'b10:   win = 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            2'b11:   win = ~last_q;
`else
            // The pointer is tracked but does not steer the fixed-priority choice.
            2'b11:   win = 1'b0 & last_q;
`endif
            default: win = 1'b0;
        endcase
    end

    // Next-state and grant decode.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    gnt       = win ? 2'b10 : 2'b01;
                    state_nxt = CALC;
                end
            end
            CALC:    state_nxt = DONE;
            DONE:    if (res_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand, owner and pointer capture on grant; sum registered in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            res_q  <= '0;
        end else begin
            if (state == IDLE && |req_i) begin
                a_q    <= win ? a1_i : a0_i;
                b_q    <= win ? b1_i : b0_i;
                id_q   <= win;
                last_q <= win;
            end
            if (state == CALC)
                res_q <= SUM_W'(a_q) + SUM_W'(b_q);
        end
    end

    // The grant is combinational from req_i, so it is also forced low while reset is held.
    assign gnt_o       = rst_n ? gnt : '0;
    assign busy_o      = (state != IDLE);
    assign res_valid_o = (state == DONE);
    assign res_o       = res_q;
    assign res_id_o    = id_q;

endmodule

// File: tb/tb_alu_add_arbiter.sv
// tb_alu_add_arbiter: scoreboard bench for alu_add_arbiter.
// A transaction-level model predicts each grant and pushes the expected
// result into a queue. A separate monitor compares that expectation against
// the DUT whenever res_valid_o is high.
module tb_alu_add_arbiter;

    localparam int DATA_W = 4;
    localparam int SUM_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_i = '0;
    logic [DATA_W-1:0] a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
    logic [1:0]        gnt_o;
    logic              busy_o, res_valid_o, res_id_o;
    logic              res_ready_i = 1'b0;
    logic [SUM_W-1:0]  res_o;

    int vectors = 0;
    int miscompares = 0;

    // Model state: 0 = waiting for a request, 1 = adding, 2 = result offered.
    int m_phase = 0;
    int m_last  = 1;
    int q_id[$];
    int q_sum[$];

    alu_add_arbiter #(.DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i),
        .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_o(res_o), .res_id_o(res_id_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [1:0] r, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        return (last == 1) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    // Advance the model by one clock edge, using the inputs presented at that edge.
    task automatic model_edge();
        int w;
        case (m_phase)
            0: if (req_i != 2'b00) begin
                   w = winner(req_i, m_last);
                   q_id.push_back(w);
                   q_sum.push_back(w ? (int'(a1_i) + int'(b1_i)) : (int'(a0_i) + int'(b0_i)));
                   m_last  = w;
                   m_phase = 1;
               end
            1: m_phase = 2;
            default: if (res_ready_i) m_phase = 0;
        endcase
    endtask

    // One cycle: drive the inputs, check the control outputs mid-cycle, then take the edge.
    task automatic step(input logic [1:0] r, input int a0, input int b0,
                        input int a1, input int b1, input logic rdy);
        int eg;
        req_i = r;
        a0_i = DATA_W'(a0); b0_i = DATA_W'(b0);
        a1_i = DATA_W'(a1); b1_i = DATA_W'(b1);
        res_ready_i = rdy;
        @(negedge clk);
        eg = (m_phase == 0 && r != 2'b00) ? (1 << winner(r, m_last)) : 0;
        chk("gnt", int'(gnt_o), eg);
        chk("busy", int'(busy_o), int'(m_phase != 0));
        chk("valid", int'(res_valid_o), int'(m_phase == 2));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Assert reset in mid-cycle, check that the outputs clear at once, then release before an edge.
    task automatic do_reset();
        req_i = '0;
        res_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", int'(gnt_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(res_valid_o), 0);
        chk("rst_res", int'(res_o), 0);
        chk("rst_id", int'(res_id_o), 0);
        m_phase = 0;
        m_last  = 1;
        q_id.delete();
        q_sum.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle that offers a result, compare it with the oldest expectation.
    // The expectation is retired on the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && res_valid_o) begin
                if (q_sum.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("res", int'(res_o), q_sum[0]);
                    chk("res_id", int'(res_id_o), q_id[0]);
                    if (res_ready_i) begin
                        void'(q_sum.pop_front());
                        void'(q_id.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single requester 0: 3 + 4.
        step(2'b01, 3, 4, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);

        // Single requester 1: maximum operands, no wrap.
        step(2'b10, 0, 0, 15, 15, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);

        // Constant contention for four operations.
        do_reset();
        for (int i = 0; i < 12; i++) step(2'b11, 1, 1, 2, 2, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);

        // Consumer stall in DONE while requests and operands move.
        step(2'b11, 5, 6, 7, 8, 1'b0);
        step(2'b11, 9, 6, 7, 8, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b11, int'($urandom_range(15)), 6, 7, 8, 1'b0);
        step(2'b11, 1, 2, 3, 4, 1'b1);
        step(2'b11, 1, 2, 3, 4, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);

        // Ready while nothing is valid, then a reset during CALC.
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b10, 0, 0, 9, 9, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b11, 2, 3, 4, 5, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);

        // Randomized traffic: requests come and go, ready is biased high.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(3)),
                 int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(15)), int'($urandom_range(15)),
                 ($urandom_range(3) != 0));
            if (i == 200) do_reset();
        end

        // Drain any outstanding result.
        for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 0, 0, 1'b1);
        chk("queue_empty", q_sum.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_add_arbiter.md
ALU_ADD_ARBITER -- requirements
Module: alu_add_arbiter

Interface
REQ-001 Parameter DATA_W, default 4, operand width of each adder input.
REQ-002 Parameter SUM_W, default 8, result width; SHALL be at least DATA_W+1.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_i  input  2  per-requester add request; bit i belongs to requester i.
REQ-007 a0_i, b0_i  input  DATA_W each  requester-0 operands.
REQ-008 a1_i, b1_i  input  DATA_W each  requester-1 operands.
REQ-009 gnt_o  output  2  one-hot, one-cycle grant pulse; operands of the granted requester are captured at that edge.
REQ-010 busy_o  output  1  high whenever state is not IDLE.
REQ-011 res_valid_o  output  1  result available.
REQ-012 res_ready_i  input  1  consumer accepts the result.
REQ-013 res_o  output  SUM_W  unsigned sum.
REQ-014 res_id_o  output  1  index of the requester that owns res_o.

Function
REQ-015 The block SHALL have three states: IDLE, CALC, DONE.
REQ-016 IDLE: if any req_i bit is high, the block SHALL assert the winner's gnt_o bit combinationally that cycle, latch its operands and ID at the clock edge, and go to CALC; otherwise it stays in IDLE with gnt_o=0.
REQ-017 CALC: the block SHALL register res_o = zero-extended A + zero-extended B (no truncation; DATA_W=4 gives a maximum of 30) and go to DONE after exactly one cycle.
REQ-018 DONE: res_valid_o SHALL be high, with res_o and res_id_o stable, until the cycle in which res_ready_i is high; the block then returns to IDLE.
REQ-019 Latency: from the grant cycle to the first res_valid_o cycle is 2 clocks; a new grant cannot occur before the cycle after the handshake, giving a minimum of 3 cycles per operation.
REQ-020 gnt_o SHALL be zero in CALC and DONE; requests arriving then wait and are neither lost nor queued beyond the live req_i level.
REQ-021 Requesters SHALL hold req_i and operands stable until granted; dropping req_i before grant withdraws the request with no side effect.
REQ-022 Operand changes after the grant edge SHALL NOT affect the in-flight result.
REQ-023 res_ready_i while res_valid_o is low SHALL be ignored.
REQ-024 A last-grant pointer SHALL update on every grant to the granted index.

Reset
REQ-025 On rst_n low, regardless of clock, the block SHALL go to IDLE and clear gnt_o, busy_o, res_valid_o, res_o, res_id_o and the operand registers to 0; the last-grant pointer SHALL be set to 1.
REQ-026 Reset during CALC or DONE SHALL discard the transaction; no result is produced after release.
REQ-027 The first arbitration after reset release SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-028 Macro ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester that is not the last-grant pointer (alternating 0,1,0,1 under constant contention).
REQ-029 Macro ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins on contention; the pointer is still maintained but unused.
REQ-030 A single requested bit SHALL always be granted, in either configuration.

Verification
REQ-031 Reset, then req_i=01, a0=3, b0=4, res_ready_i=1 -> gnt_o=01 in cycle 0, res_valid_o in cycle 2 with res_o=7, res_id_o=0, busy_o=0 in cycle 3.
REQ-032 req_i=10, a1=15, b1=15 -> res_o=30 (8'h1E), res_id_o=1; no wrap.
REQ-033 req_i=11 held for 4 operations, operands a0=1,b0=1,a1=2,b1=2 -> with the macro, res_id sequence 0,1,0,1 and res 2,4,2,4; without the macro, 0,0,0,0.
REQ-034 res_ready_i held low for 5 cycles in DONE while a0 changes and req_i=11 -> res_valid_o and res_o are stable and gnt_o=00 throughout; a grant follows the cycle after res_ready_i=1.
REQ-035 rst_n pulsed low asynchronously in mid-cycle during CALC -> all outputs are 0 immediately, no res_valid_o afterwards, and the next contended grant goes to requester 0.
